// File: rtl/lagarto_fp_multiplier_core.sv
// Pipelined binary64 multiplier datapath: special-case select, 53x53 multiply, normalise/round.
// Define LAGARTO_FP_MUL_EXTRA_PIPE_EN to split the multiply into two registered halves (+1 cycle latency).
module lagarto_fp_multiplier_core #(
    parameter logic [63:0] CANONICAL_NAN = 64'h7FF8000000000000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        kill_i,
    input  logic        op_valid_i,
    input  logic [63:0] operand_a_i,
    input  logic [63:0] operand_b_i,
    input  logic [2:0]  rm_i,
    input  logic        invalid_operation_i,
    input  logic        is_snan_i,
    input  logic        is_qnan_i,
    input  logic        is_zero_i,
    input  logic        is_inf_i,
    output logic [63:0] result_o,
    output logic [4:0]  fflags_o,
    output logic        result_valid_o,
    output logic        busy_o
);

    typedef struct packed {
        logic               special;
        logic [63:0]        sres;
        logic [4:0]         sflags;
        logic               sign;
        logic signed [12:0] exp;
        logic [2:0]         rm;
    } side_t;

    // The operand-check stage folds 0 x inf into is_snan_i, so this flag carries no extra information.
    logic unused_invalid;
    assign unused_invalid = invalid_operation_i;

    logic         valid1, valid2, valid3;
    side_t        side1_d, side1, side2, side3_d, side3;
    logic [52:0]  ma1, mb1;
    logic [105:0] prod2;
    logic [51:0]  mant3_d, mant3;
    logic         guard3_d, guard3, sticky3_d, sticky3;

    always_comb begin
        side1_d      = '0;
        side1_d.sign = operand_a_i[63] ^ operand_b_i[63];
        side1_d.rm   = (rm_i > 3'd4) ? 3'd0 : rm_i;
        side1_d.exp  = $signed({2'b00, operand_a_i[62:52]}) + $signed({2'b00, operand_b_i[62:52]})
                       - 13'sd1023;
        if (is_snan_i || is_qnan_i) begin
            side1_d.special = 1'b1;
            side1_d.sres    = CANONICAL_NAN;
            side1_d.sflags  = {is_snan_i, 4'b0000};
        end else if (is_inf_i) begin
            side1_d.special = 1'b1;
            side1_d.sres    = {side1_d.sign, 11'h7FF, 52'b0};
        end else if (is_zero_i || operand_a_i[62:52] == 11'd0 || operand_b_i[62:52] == 11'd0) begin
            side1_d.special = 1'b1;
            side1_d.sres    = {side1_d.sign, 63'b0};
        end
    end

`ifdef LAGARTO_FP_MUL_EXTRA_PIPE_EN
    logic         valid2a;
    side_t        side2a;
    logic [79:0]  pp_lo;
    logic [78:0]  pp_hi;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid1         <= 1'b0;
            valid2         <= 1'b0;
            valid3         <= 1'b0;
            result_valid_o <= 1'b0;
`ifdef LAGARTO_FP_MUL_EXTRA_PIPE_EN
            valid2a        <= 1'b0;
`endif
        end else begin
            valid1         <= op_valid_i & ~kill_i;
`ifdef LAGARTO_FP_MUL_EXTRA_PIPE_EN
            valid2a        <= valid1 & ~kill_i;
            valid2         <= valid2a & ~kill_i;
`else
            valid2         <= valid1 & ~kill_i;
`endif
            valid3         <= valid2 & ~kill_i;
            result_valid_o <= valid3 & ~kill_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            side1   <= '0;
            ma1     <= '0;
            mb1     <= '0;
            side2   <= '0;
            prod2   <= '0;
            side3   <= '0;
            mant3   <= '0;
            guard3  <= 1'b0;
            sticky3 <= 1'b0;
`ifdef LAGARTO_FP_MUL_EXTRA_PIPE_EN
            side2a  <= '0;
            pp_lo   <= '0;
            pp_hi   <= '0;
`endif
        end else begin
            side1   <= side1_d;
            ma1     <= {1'b1, operand_a_i[51:0]};
            mb1     <= {1'b1, operand_b_i[51:0]};
`ifdef LAGARTO_FP_MUL_EXTRA_PIPE_EN
            // Split on mb bit 27: low and high partial products, recombined next cycle.
            side2a  <= side1;
            pp_lo   <= {27'b0, ma1} * {53'b0, mb1[26:0]};
            pp_hi   <= {26'b0, ma1} * {53'b0, mb1[52:27]};
            side2   <= side2a;
            prod2   <= {26'b0, pp_lo} + {pp_hi, 27'b0};
`else
            side2   <= side1;
            prod2   <= {53'b0, ma1} * {53'b0, mb1};
`endif
            side3   <= side3_d;
            mant3   <= mant3_d;
            guard3  <= guard3_d;
            sticky3 <= sticky3_d;
        end
    end

    always_comb begin
        side3_d     = side2;
        side3_d.exp = side2.exp + 13'(prod2[105]);
        if (prod2[105]) begin
            mant3_d   = prod2[104:53];
            guard3_d  = prod2[52];
            sticky3_d = |prod2[51:0];
        end else begin
            mant3_d   = prod2[103:52];
            guard3_d  = prod2[51];
            sticky3_d = |prod2[50:0];
        end
    end

    logic               round_up, ovf_to_inf, inexact;
    logic [52:0]        mant_r;
    logic signed [12:0] exp_r;
    logic [63:0]        res_d;
    logic [4:0]         flags_d;

    always_comb begin
        inexact = guard3 | sticky3;
        case (side3.rm)
            3'd1:    round_up = 1'b0;
            3'd2:    round_up = side3.sign & inexact;
            3'd3:    round_up = ~side3.sign & inexact;
            3'd4:    round_up = guard3;
            default: round_up = guard3 & (sticky3 | mant3[0]);
        endcase
        mant_r     = {1'b0, mant3} + 53'(round_up);
        exp_r      = side3.exp + 13'(mant_r[52]);
        ovf_to_inf = (side3.rm == 3'd0) || (side3.rm == 3'd4) ||
                     (side3.rm == 3'd3 && !side3.sign) || (side3.rm == 3'd2 && side3.sign);
        if (side3.special) begin
            res_d   = side3.sres;
            flags_d = side3.sflags;
        end else if (exp_r >= 13'sd2047) begin
            res_d   = ovf_to_inf ? {side3.sign, 11'h7FF, 52'b0} : {side3.sign, 11'h7FE, {52{1'b1}}};
            flags_d = 5'b00101;
        end else if (exp_r <= 13'sd0) begin
            res_d   = {side3.sign, 63'b0};
            flags_d = 5'b00011;
        end else begin
            res_d   = {side3.sign, exp_r[10:0], mant_r[51:0]};
            flags_d = {4'b0000, inexact};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            result_o <= '0;
            fflags_o <= '0;
        end else if (valid3) begin
            result_o <= res_d;
            fflags_o <= flags_d;
        end
    end

`ifdef LAGARTO_FP_MUL_EXTRA_PIPE_EN
    assign busy_o = valid1 | valid2a | valid2 | valid3 | result_valid_o;
`else
    assign busy_o = valid1 | valid2 | valid3 | result_valid_o;
`endif

endmodule

// File: doc/lagarto_fp_multiplier_core.md
# lagarto_fp_multiplier_core

Pipelined IEEE-754 double-precision multiplier datapath for the Lagarto FPU. It sits directly downstream of the multiplier operand-check stage and consumes that stage's classification flags together with the raw operands. Each issued operation produces a rounded 64-bit result and RISC-V accrued exception flags after a fixed latency. It accepts one operation per cycle, with no backpressure, and supports a pipeline kill.

## Interface
Parameters:
- CANONICAL_NAN, 64'h7FF8000000000000, value returned for every NaN result.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- kill_i  in  1  synchronous flush of all in-flight operations.
- op_valid_i  in  1  issue strobe; operands and flags are sampled when high.
- operand_a_i, operand_b_i  in  64  IEEE-754 binary64 operands.
- rm_i  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
- invalid_operation_i, is_snan_i, is_qnan_i, is_zero_i, is_inf_i  in  1 each  operand-check flags, valid in the same cycle as op_valid_i.
- result_o  out  64  product.
- fflags_o  out  5  {NV, DZ, OF, UF, NX}, bit 4 down to bit 0.
- result_valid_o  out  1  result_o and fflags_o are valid this cycle.
- busy_o  out  1  OR of all stage-valid registers.

## Operation
- **Special-case selection** (stage 1, priority order):
  - NaN: if is_snan_i or is_qnan_i, result is CANONICAL_NAN. NV = is_snan_i. The is_snan_i flag already includes 0×inf.
  - Inf: else if is_inf_i, result is {sa^sb, 11'h7FF, 52'b0}, flags 0.
  - Zero: else if is_zero_i, or either exponent field is 0 (DAZ: subnormal inputs are treated as zero), result is {sa^sb, 63'b0}, flags 0.
  - Subnormal × inf follows is_inf_i and returns inf.
  - Otherwise the operation takes the normal path.
- **Normal path**:
  - Significands: ma = {1, fa}, mb = {1, fb}, both 53 bits. The product P = ma*mb is 106 bits.
  - Exponent: E = ea + eb − 1023, held as a 13-bit signed value.
  - Normalisation: if P[105] is set, take mantissa P[104:53], guard P[52], sticky |P[51:0], and E+1. Otherwise take mantissa P[103:52], guard P[51], sticky |P[50:0].
- **Rounding**:
  - Round-up conditions:
    - RNE: guard & (sticky | lsb).
    - RTZ: never.
    - RDN: sign & (guard | sticky).
    - RUP: ~sign & (guard | sticky).
    - RMM: guard.
  - rm_i values 5–7 are handled as RNE with no flag.
  - A mantissa carry-out zeroes the mantissa and increments E.
  - NX = guard | sticky.
- **Overflow** (E ≥ 2047 after rounding): set OF and NX. The result is ±inf for RNE, RMM, RUP with positive sign, and RDN with negative sign. All other cases give ±0x7FEFFFFFFFFFFFFF.
- **Underflow** (E ≤ 0 after rounding): flush to signed zero and set UF and NX.
- DZ is always 0.

## Timing
- Latency is 3 cycles: an operation sampled at edge N appears with result_valid_o high after edge N+3.
- Throughput is one operation per cycle, with no stall.
- Stages:
  - S1: unpack and special-case selection.
  - S2: 53×53 multiply.
  - S3: normalise, round, and output register.
- Reset values: result_o = 0, fflags_o = 0, result_valid_o = 0, busy_o = 0, and all stage valids = 0.
- result_o and fflags_o hold their last value while result_valid_o = 0.
- kill_i:
  - At the edge where it is high, all stage valids clear, including an op_valid_i asserted in that same cycle.
  - result_valid_o is 0 from the next cycle.
  - Data registers need not clear.
- A reset asserted mid-operation discards all in-flight operations immediately, since the reset is asynchronous.
- Back-to-back issue with different rm_i values is legal: rm travels with its own operation.

## Configuration
- LAGARTO_FP_MUL_EXTRA_PIPE_EN defined: S2 is split into two registered halves (partial-product array, then final add). Latency becomes 4 cycles; throughput is unchanged.
- Not defined: latency is 3 cycles as specified above.

## Test plan
- 0x4000000000000000 × 0x4008000000000000, RNE → 0x4018000000000000, fflags 0, result_valid_o exactly 3 cycles after issue (4 with the macro).
- Operands 0 × 0x7FF0000000000000 with is_snan_i = invalid_operation_i = 1 → 0x7FF8000000000000, fflags 5'b10000.
- 0x7FEFFFFFFFFFFFFF × 0x4000000000000000:
  - RTZ → 0x7FEFFFFFFFFFFFFF, fflags 5'b00101.
  - RNE → 0x7FF0000000000000, fflags 5'b00101.
- 0x3FF0000000000001 squared:
  - RNE → 0x3FF0000000000002, fflags 5'b00001.
  - RUP → 0x3FF0000000000003.
- 0x0010000000000000 × 0x3FE0000000000000, RNE → 0x0000000000000000, fflags 5'b00011. Sign check: with a negative operand → 0x8000000000000000.
- Issue 3 back-to-back ops with kill_i high on the 3rd issue cycle → no result_valid_o pulses. Then assert rstn_i low mid-stream → all outputs 0 and busy_o = 0 immediately.
